hidden_layer_sequencer: RTL
===========================

Name: hidden_layer_sequencer

Overview:
Time-multiplexed controller for the hidden layer. One shared 8x8 multiply-accumulate unit walks all weights of each neuron in turn. Each sum is saturated to the sigmoid range, then looked up in the external sigmoid LUT, and the activated byte is written to the layer output buffer. It sits between the input-pixel buffer and weight ROM on one side and the sigmoid LUT and output buffer on the other, and it is started by the top-level recognizer FSM.

Parameters:
N_INPUTS, 37, inputs per neuron (weights per neuron)
N_NEURONS, 16, neurons in the layer
SUM_MIN, -32768, saturation floor before the sigmoid
SUM_MAX, 32767, saturation ceiling before the sigmoid
LUT_LAT, 1, sigmoid LUT read latency in cycles (1..4)

Ports:
clk  in  1  system clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle request to evaluate the layer; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last output write
in_addr  out  6  input buffer read address (0..N_INPUTS-1)
in_data  in  8  unsigned input byte; valid 1 cycle after in_addr
w_addr  out  10  weight ROM address = neuron*N_INPUTS + input index
w_data  in  8  signed weight; valid 1 cycle after w_addr
lut_addr  out  16  sigmoid LUT address
lut_data  in  8  activated value; valid LUT_LAT cycles after lut_addr
out_we  out  1  output buffer write strobe
out_addr  out  4  output buffer address = neuron index
out_data  out  8  activated neuron value

Behaviour:
- Reset: all of the following are 0: state=IDLE, busy, done, out_we, in_addr, w_addr, lut_addr, out_addr, out_data, accumulator, neuron index.
- States and transitions:
  - IDLE: stays here until start=1.
  - MAC: lasts exactly N_INPUTS cycles and issues index k=0..N_INPUTS-1 on in_addr and w_addr.
  - DRAIN: 1 cycle; accumulates the last product.
  - SAT: 1 cycle.
  - LUT: LUT_LAT cycles.
  - WRITE: 1 cycle. Goes to MAC for the next neuron, or to FIN after neuron N_NEURONS-1.
  - FIN: 1 cycle; done=1, busy=0, then back to IDLE.
- Accepting start in IDLE:
  - Clears the accumulator and the neuron index.
  - Sets busy=1.
  - Enters MAC on the next edge.
  - start in any other state is ignored.
- MAC datapath:
  - A 1-cycle registered valid tracks each issued address.
  - On valid, the accumulator adds the 16-bit product zero_ext(in_data) * sign(w_data).
  - The accumulator is 32-bit signed and never wraps for the default sizes; worst case magnitude is 37*255*128 = 1,207,680.
- SAT: sat = clamp(acc, SUM_MIN, SUM_MAX), truncated to a 16-bit signed value. lut_addr = sat XOR 0x8000 (offset binary: -32768 maps to 0x0000, 0 maps to 0x8000, 32767 maps to 0xFFFF). lut_addr is held through the LUT state.
- WRITE:
  - out_we=1 for 1 cycle, out_addr = neuron index, out_data = lut_data captured at the end of the LUT state.
  - The accumulator is cleared and the neuron index is incremented in the same edge.
  - out_data holds its value until the next write.
- Per-neuron latency is N_INPUTS + 3 + LUT_LAT cycles (41 with defaults).
  - With start accepted at edge 0, the first out_we is high in cycle 41.
  - done is high in cycle 16*41 + 1 = 657.
- Outside MAC the addresses hold their last value; memories may be read freely.
- rst mid-operation:
  - Takes effect at the next edge: back to IDLE, all outputs at reset values.
  - No partial write and no done pulse.
  - A start that coincides with rst is ignored.
- start asserted in the FIN cycle is ignored. start asserted in the first IDLE cycle after FIN is accepted, giving a back-to-back run.

Test Plan:
- Unit sum: all in_data=1, all w_data=+1, LUT returns addr[15:8] -> every neuron has lut_addr=0x8025 (37+32768); out_data=0x80 written to out_addr 0..15; done in cycle 657.
- Positive saturation: in_data=255, w_data=+127 (sum 1,198,245) -> lut_addr=0xFFFF for every neuron.
- Negative saturation: in_data=255, w_data=-128 (sum -1,207,680) -> lut_addr=0x0000; mixed signs with in_data=k, w_data alternating +1/-1 -> lut_addr=0x8000 when the terms cancel.
- Addressing and latency: check that w_addr runs 0..36 for neuron 0 and 37..73 for neuron 1; out_we spacing is exactly 41 cycles; rerun with LUT_LAT=3 -> spacing 43.
- start pulsed while busy, and again in the FIN cycle -> ignored; start in the following IDLE cycle -> a second full run with identical writes.
- rst asserted in the MAC state of neuron 5 -> next cycle busy=0, out_we=0, no done pulse; a fresh start writes neurons 0..15 cleanly.

Source files
------------

// File: rtl/hidden_layer_sequencer.sv
// hidden_layer_sequencer
//   Time-multiplexed hidden-layer controller. One shared 8x8 MAC walks all
//   weights of each neuron in turn. Each sum is clamped to the sigmoid input
//   range and looked up in an external sigmoid LUT. The activated byte is then
//   written to the layer output buffer.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     one-cycle layer request, only honoured in idle
//   busy      high while a layer evaluation is in flight
//   done      one-cycle pulse after the last output write
//   in_addr   input-pixel buffer address (input index)
//   in_data   unsigned pixel byte, valid one cycle after in_addr
//   w_addr    weight ROM address (neuron * N_INPUTS + input index)
//   w_data    signed weight byte, valid one cycle after w_addr
//   lut_addr  sigmoid LUT address (offset-binary saturated sum)
//   lut_data  activated byte, valid LUT_LAT cycles after lut_addr
//   out_we    output buffer write strobe
//   out_addr  output buffer address (neuron index)
//   out_data  activated neuron value, held until the next write
module hidden_layer_sequencer #(
   parameter int N_INPUTS  = 37,
   parameter int N_NEURONS = 16,
   parameter int SUM_MIN   = -32768,
   parameter int SUM_MAX   = 32767,
   parameter int LUT_LAT   = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [5:0]  in_addr,
   input  logic [7:0]  in_data,
   output logic [9:0]  w_addr,
   input  logic [7:0]  w_data,
   output logic [15:0] lut_addr,
   input  logic [7:0]  lut_data,
   output logic        out_we,
   output logic [3:0]  out_addr,
   output logic [7:0]  out_data
);

   typedef enum logic [2:0] {
      StIdle,
      StMac,
      StDrain,
      StSat,
      StLut,
      StWrite,
      StFin
   } state_e;

   state_e             state_q, state_d;
   logic [5:0]         in_addr_q, in_addr_d;
   logic [9:0]         w_addr_q, w_addr_d;
   logic [15:0]        lut_addr_q, lut_addr_d;
   logic [7:0]         out_data_q, out_data_d;
   logic signed [31:0] acc_q, acc_d;
   logic [3:0]         neuron_q, neuron_d;
   logic               valid_q, valid_d;
   logic [1:0]         lut_cnt_q, lut_cnt_d;

   logic signed [16:0] in_ext, w_ext, prod;
   logic signed [31:0] prod_ext;
   logic signed [15:0] sat;
   logic [15:0]        sat_addr;

   // Unsigned pixel times signed weight; 17 bits hold the full product range.
   always_comb begin
      in_ext   = {9'b0, in_data};
      w_ext    = {{9{w_data[7]}}, w_data};
      prod     = in_ext * w_ext;
      prod_ext = {{15{prod[16]}}, prod};
   end

   always_comb begin
      if (acc_q > SUM_MAX) begin
         sat = 16'(SUM_MAX);
      end else if (acc_q < SUM_MIN) begin
         sat = 16'(SUM_MIN);
      end else begin
         sat = acc_q[15:0];
      end
      // Offset binary: flipping the sign bit maps -32768..32767 onto 0..0xFFFF.
      sat_addr = sat ^ 16'h8000;
   end

   always_comb begin
      state_d    = state_q;
      in_addr_d  = in_addr_q;
      w_addr_d   = w_addr_q;
      lut_addr_d = lut_addr_q;
      out_data_d = out_data_q;
      acc_d      = acc_q;
      neuron_d   = neuron_q;
      valid_d    = 1'b0;
      lut_cnt_d  = lut_cnt_q;

      // Operands arrive one cycle after their address, so accumulate on the
      // registered valid; this also covers the DRAIN cycle.
      if (valid_q) begin
         acc_d = acc_q + prod_ext;
      end

      case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StMac;
               acc_d     = '0;
               neuron_d  = '0;
               in_addr_d = '0;
               w_addr_d  = '0;
            end
         end
         StMac: begin
            valid_d = 1'b1;
            if (in_addr_q == 6'(N_INPUTS - 1)) begin
               state_d = StDrain;
            end else begin
               in_addr_d = in_addr_q + 6'd1;
               w_addr_d  = w_addr_q + 10'd1;
            end
         end
         StDrain: begin
            state_d = StSat;
         end
         StSat: begin
            lut_addr_d = sat_addr;
            lut_cnt_d  = '0;
            state_d    = StLut;
         end
         StLut: begin
            if (lut_cnt_q == 2'(LUT_LAT - 1)) begin
               out_data_d = lut_data;
               state_d    = StWrite;
            end else begin
               lut_cnt_d = lut_cnt_q + 2'd1;
            end
         end
         StWrite: begin
            acc_d    = '0;
            neuron_d = neuron_q + 4'd1;
            if (neuron_q == 4'(N_NEURONS - 1)) begin
               state_d = StFin;
            end else begin
               state_d   = StMac;
               in_addr_d = '0;
               // w_addr holds the last weight of this neuron; the next one follows it.
               w_addr_d  = w_addr_q + 10'd1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         in_addr_q  <= '0;
         w_addr_q   <= '0;
         lut_addr_q <= '0;
         out_data_q <= '0;
         acc_q      <= '0;
         neuron_q   <= '0;
         valid_q    <= 1'b0;
         lut_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         in_addr_q  <= in_addr_d;
         w_addr_q   <= w_addr_d;
         lut_addr_q <= lut_addr_d;
         out_data_q <= out_data_d;
         acc_q      <= acc_d;
         neuron_q   <= neuron_d;
         valid_q    <= valid_d;
         lut_cnt_q  <= lut_cnt_d;
      end
   end

   always_comb begin
      busy     = (state_q != StIdle) && (state_q != StFin);
      done     = (state_q == StFin);
      out_we   = (state_q == StWrite);
      out_addr = neuron_q;
      in_addr  = in_addr_q;
      w_addr   = w_addr_q;
      out_data = out_data_q;
      // The LUT address is presented during SAT so the LUT's read latency
      // lines up with the LUT state; the register then holds it.
      lut_addr = (state_q == StSat) ? sat_addr : lut_addr_q;
   end

endmodule
